// File: rtl/gabor_pkg.sv
// Shared constants, types and address helpers for the Gabor 5x5 window fetch path.
package gabor_pkg;

   localparam int unsigned ADDR_W     = 19;
   localparam int unsigned PIX_W      = 8;
   localparam int unsigned OUT_W      = 10;
   localparam int unsigned ROW_STRIDE = 516;
   localparam int unsigned WIN        = 5;
   localparam int unsigned IMG_DEPTH  = 266256;
   localparam int unsigned COL_W      = 3;

   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [OUT_W-1:0] opix_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_PRESENT
   } fetch_state_e;

   typedef enum logic [1:0] {
      KIND_HIT,
      KIND_SHIFT,
      KIND_FULL
   } fetch_kind_e;

   typedef struct packed {
      logic             valid;
      logic [COL_W-1:0] col;
   } rd_tag_t;

   // Byte address of one row of a window column.
   function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] col_addr,
                                                  input int unsigned row);
      return ADDR_W'(32'(col_addr) + row * ROW_STRIDE);
   endfunction

   // Checked at 32 bits so a row near the image end cannot wrap back into range.
   function automatic logic row_in_range(input logic [ADDR_W-1:0] col_addr,
                                         input int unsigned row);
      return (32'(col_addr) + row * ROW_STRIDE) < IMG_DEPTH;
   endfunction

endpackage

// File: rtl/gabor_rd_tag_pipe.sv
// Delay line carrying the destination column of each issued read until its data returns.
module gabor_rd_tag_pipe
   import gabor_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   rd_tag_t pipe_q [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= tag_in;
         for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/gabor_window_fetch.sv
// Serves 5x5 pixel windows to the Gabor core from a row-banked padded image BRAM,
// reusing the previous window on a same-address hit or a one-column step.
module gabor_window_fetch
   import gabor_pkg::*;
#(
   parameter int unsigned BRAM_LAT = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         req_valid,
   input  logic [ADDR_W-1:0]            req_addr,
   output logic                         req_ready,
   output logic                         mem_re,
   output logic [WIN*ADDR_W-1:0]        mem_addr,
   input  logic [WIN*PIX_W-1:0]         mem_rdata,
   output logic                         win_valid,
   input  logic                         win_ready,
   output logic [WIN*WIN*OUT_W-1:0]     win_pixels
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIN - 1);

   fetch_state_e          state_q, state_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [ADDR_W-1:0]     last_q, last_d;
   logic                  cache_valid_q, cache_valid_d;
   logic                  iss_valid_q, iss_valid_d;
   logic                  req_ready_d, mem_re_d, win_valid_d;
   logic [WIN*ADDR_W-1:0] mem_addr_d;
   logic                  accept_c, issue_c, shift_c;
   logic [ADDR_W-1:0]     issue_base_c;
   fetch_kind_e           kind_c;
   rd_tag_t               tag_in_c, tag_out;
   pix_t                  win_q [WIN][WIN];

   assign tag_in_c = '{valid: iss_valid_q, col: col_q};

   gabor_rd_tag_pipe #(.DEPTH(BRAM_LAT)) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in_c),
      .tag_out (tag_out)
   );

   // Next-state, request classification and read issue.
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      base_d        = base_q;
      last_d        = last_q;
      cache_valid_d = cache_valid_q;
      iss_valid_d   = 1'b0;
      mem_re_d      = 1'b0;
      mem_addr_d    = mem_addr;
      win_valid_d   = win_valid;
      issue_c       = 1'b0;
      shift_c       = 1'b0;
      issue_base_c  = base_q;
      accept_c      = (state_q == ST_IDLE) && req_valid && req_ready;

      kind_c = KIND_FULL;
      if (cache_valid_q && !flush) begin
         if (req_addr == last_q)                    kind_c = KIND_HIT;
         else if (req_addr == last_q + ADDR_W'(1))  kind_c = KIND_SHIFT;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               base_d       = req_addr;
               last_d       = req_addr;
               issue_base_c = req_addr;
               case (kind_c)
                  KIND_HIT: begin
                     state_d     = ST_PRESENT;
                     win_valid_d = 1'b1;
                  end
                  KIND_SHIFT: begin
                     state_d = ST_FETCH;
                     col_d   = LAST_COL;
                     issue_c = 1'b1;
                     shift_c = 1'b1;
                  end
                  default: begin
                     state_d = ST_FETCH;
                     col_d   = '0;
                     issue_c = 1'b1;
                  end
               endcase
            end
         end
         ST_FETCH: begin
            if (col_q == LAST_COL) begin
               state_d = ST_DRAIN;
            end else begin
               col_d   = col_q + COL_W'(1);
               issue_c = 1'b1;
            end
         end
         ST_DRAIN: begin
            // Column 4 is always the last read of a fetch, so its return completes the window.
            if (tag_out.valid && tag_out.col == LAST_COL) begin
               state_d     = ST_PRESENT;
               win_valid_d = 1'b1;
            end
         end
         ST_PRESENT: begin
            if (win_ready) begin
               state_d     = ST_IDLE;
               win_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A column whose rows are all past the image end still takes its cycle, without a strobe.
      if (issue_c) begin
         iss_valid_d = 1'b1;
         for (int unsigned k = 0; k < WIN; k++) begin
            mem_addr_d[k*ADDR_W +: ADDR_W] = row_addr(issue_base_c + ADDR_W'(col_d), k);
            if (row_in_range(issue_base_c + ADDR_W'(col_d), k)) mem_re_d = 1'b1;
         end
      end

      req_ready_d = (state_d == ST_IDLE);

      if (flush)         cache_valid_d = 1'b0;
      else if (accept_c) cache_valid_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         col_q         <= '0;
         base_q        <= '0;
         last_q        <= '0;
         cache_valid_q <= 1'b0;
         iss_valid_q   <= 1'b0;
         req_ready     <= 1'b0;
         mem_re        <= 1'b0;
         mem_addr      <= '0;
         win_valid     <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         base_q        <= base_d;
         last_q        <= last_d;
         cache_valid_q <= cache_valid_d;
         iss_valid_q   <= iss_valid_d;
         req_ready     <= req_ready_d;
         mem_re        <= mem_re_d;
         mem_addr      <= mem_addr_d;
         win_valid     <= win_valid_d;
      end
   end

   // Window store: column shift on a one-step request, slot load when read data returns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned r = 0; r < WIN; r++)
            for (int unsigned c = 0; c < WIN; c++) win_q[r][c] <= '0;
      end else begin
         if (shift_c) begin
            for (int unsigned r = 0; r < WIN; r++)
               for (int unsigned c = 0; c < WIN - 1; c++) win_q[r][c] <= win_q[r][c+1];
         end
         for (int unsigned c = 0; c < WIN; c++) begin
            if (tag_out.valid && tag_out.col == COL_W'(c)) begin
               for (int unsigned r = 0; r < WIN; r++) begin
                  win_q[r][c] <= row_in_range(base_q + ADDR_W'(c), r)
                                 ? mem_rdata[r*PIX_W +: PIX_W] : '0;
               end
            end
         end
      end
   end

   always_comb begin
      win_pixels = '0;
      for (int unsigned r = 0; r < WIN; r++)
         for (int unsigned c = 0; c < WIN; c++)
            win_pixels[(r*WIN + c)*OUT_W +: OUT_W] = opix_t'(win_q[r][c]);
   end

endmodule
